// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: internal word RAM plus MMIO registers (LED, switch, number, timer).
// Optional free-running timer register is built only when DATA_RESP_TIMER_EN is defined.
module data_sram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] RAM_BASE  = 32'h1C00_0000,
  parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  localparam int RAM_WORDS = 1 << ADDR_W;

  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_SWITCH = 16'hF004;
  localparam logic [15:0] OFF_NUM    = 16'hF008;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;

  logic [31:0]       ram [RAM_WORDS];
  logic [ADDR_W-1:0] ram_idx;
  logic [15:0]       offset;
  logic              ram_hit;
  logic              mmio_hit;
  logic              rd_req;
  logic              wr_req;
  logic              ram_wr;
  logic              led_wr;
  logic              num_wr;
  logic [31:0]       lane_mask;
  logic [31:0]       mmio_rdata;
  logic [31:0]       timer_rdata;
  logic [15:0]       led_reg;
  logic [31:0]       num_reg;
  logic [15:0]       sw_meta;
  logic [15:0]       sw_sync;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^data_sram_addr[1:0];

  assign ram_idx  = data_sram_addr[ADDR_W+1:2];
  assign offset   = data_sram_addr[15:0];
  assign ram_hit  = (data_sram_addr[31:ADDR_W+2] == RAM_BASE[31:ADDR_W+2]);
  assign mmio_hit = (data_sram_addr[31:16] == MMIO_BASE);
  assign rd_req   = data_sram_en && (data_sram_we == 4'h0);
  assign wr_req   = data_sram_en && (data_sram_we != 4'h0);
  assign ram_wr   = wr_req && ram_hit;
  assign led_wr   = wr_req && mmio_hit && (offset == OFF_LED);
  assign num_wr   = wr_req && mmio_hit && (offset == OFF_NUM);

  // Byte strobes expanded to a bit mask so every register merges lanes the same way.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign lane_mask[gi*8 +: 8] = {8{data_sram_we[gi]}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_we[b]) begin
          ram[ram_idx][b*8 +: 8] <= data_sram_wdata[b*8 +: 8];
        end
      end
    end
  end

`ifdef DATA_RESP_TIMER_EN
  logic [31:0] timer_reg;
  logic        timer_wr;

  assign timer_wr = wr_req && mmio_hit && (offset == OFF_TIMER);

  // A write replaces that edge's increment; counting resumes on the next edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_reg <= 32'h0;
    end else if (timer_wr) begin
      timer_reg <= (timer_reg & ~lane_mask) | (data_sram_wdata & lane_mask);
    end else begin
      timer_reg <= timer_reg + 32'd1;
    end
  end

  assign timer_rdata = timer_reg;
`else
  assign timer_rdata = 32'h0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_reg <= 16'h0;
      num_reg <= 32'h0;
      sw_meta <= 16'h0;
      sw_sync <= 16'h0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
      if (led_wr) begin
        led_reg <= (led_reg & ~lane_mask[15:0]) | (data_sram_wdata[15:0] & lane_mask[15:0]);
      end
      if (num_wr) begin
        num_reg <= (num_reg & ~lane_mask) | (data_sram_wdata & lane_mask);
      end
    end
  end

  always_comb begin
    mmio_rdata = 32'h0;
    case (offset)
      OFF_LED:    mmio_rdata = {16'h0, led_reg};
      OFF_SWITCH: mmio_rdata = {16'h0, sw_sync};
      OFF_NUM:    mmio_rdata = num_reg;
      OFF_TIMER:  mmio_rdata = timer_rdata;
      default:    mmio_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sram_rdata <= 32'h0;
    end else if (rd_req) begin
      if (ram_hit) begin
        data_sram_rdata <= ram[ram_idx];
      end else if (mmio_hit) begin
        data_sram_rdata <= mmio_rdata;
      end else begin
        data_sram_rdata <= 32'h0;
      end
    end
  end

  assign led      = led_reg;
  assign num_data = num_reg;

endmodule
